// File: rtl/register_bank_pkg.sv
// Shared constants and types for the 8 x 16-bit register bank.
// The top module's parameters default to these values.
package register_bank_pkg;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t R0_INDEX = '0;

endpackage

// File: rtl/register_bank_cell.sv
// One storage word of the register bank.
// Reset takes priority over a write in the same cycle.
module register_bank_cell #(
    parameter int WIDTH = register_bank_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_write,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (enable_write) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_bank.sv
// 8-entry register bank: one write port, two registered read ports with
// write-first bypass, optional hardwired-zero entry 0, and a written bitmap.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH   = register_bank_pkg::WIDTH,
    parameter int DEPTH   = register_bank_pkg::DEPTH,
    parameter int ADDR_W  = register_bank_pkg::ADDR_W,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [WIDTH-1:0]  read_data_a,
    output logic [WIDTH-1:0]  read_data_b,
    output logic [DEPTH-1:0]  written_mask
);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic             write_legal;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    // Writes to entry 0 are dropped entirely when it is hardwired to zero.
    assign write_legal = enable_write &&
                         !(ZERO_R0 && (write_addr == ADDR_W'(R0_INDEX)));

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        register_bank_cell #(.WIDTH(WIDTH)) u_cell (
            .clock        (clock),
            .reset        (reset),
            .enable_write (write_legal && (write_addr == ADDR_W'(i))),
            .d            (write_data),
            .q            (entry_q[i])
        );
    end

    // Zero-entry masking wins over bypass, bypass wins over stored data.
    always_comb begin
        next_a = entry_q[read_addr_a];
        next_b = entry_q[read_addr_b];
        if (write_legal && (read_addr_a == write_addr)) begin
            next_a = write_data;
        end
        if (write_legal && (read_addr_b == write_addr)) begin
            next_b = write_data;
        end
        if (ZERO_R0 && (read_addr_a == ADDR_W'(R0_INDEX))) begin
            next_a = '0;
        end
        if (ZERO_R0 && (read_addr_b == ADDR_W'(R0_INDEX))) begin
            next_b = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_a  <= '0;
            read_data_b  <= '0;
            written_mask <= '0;
        end else begin
            read_data_a <= next_a;
            read_data_b <= next_b;
            if (write_legal) begin
                written_mask[write_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed steps followed by random
// traffic, all compared against an array-based model of the bank.
module tb_register_bank;

    logic        clock;
    logic        reset;
    logic        enable_write;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic [2:0]  read_addr_a;
    logic [2:0]  read_addr_b;
    logic [15:0] read_data_a;
    logic [15:0] read_data_b;
    logic [7:0]  written_mask;

    logic [15:0] model_mem [8];
    logic [7:0]  model_mask;
    logic [15:0] exp_a;
    logic [15:0] exp_b;

    int check_count = 0;
    int pass_count  = 0;

    register_bank dut (
        .clock        (clock),
        .reset        (reset),
        .enable_write (enable_write),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr_a  (read_addr_a),
        .read_addr_b  (read_addr_b),
        .read_data_a  (read_data_a),
        .read_data_b  (read_data_b),
        .written_mask (written_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
    endtask

    // Drive one cycle of inputs, advance the model through the edge, then compare.
    task automatic applyStimulus(input logic rst, input logic we,
                                 input logic [2:0] wa, input logic [15:0] wd,
                                 input logic [2:0] ra, input logic [2:0] rb);
        logic legal;
        @(negedge clock);
        reset        = rst;
        enable_write = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr_a  = ra;
        read_addr_b  = rb;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
            model_mask = 8'h00;
            exp_a = 16'h0000;
            exp_b = 16'h0000;
        end else begin
            legal = we && (wa != 3'd0);
            exp_a = (ra == 3'd0) ? 16'h0000 : ((legal && wa == ra) ? wd : model_mem[ra]);
            exp_b = (rb == 3'd0) ? 16'h0000 : ((legal && wa == rb) ? wd : model_mem[rb]);
            if (legal) begin
                model_mem[wa]  = wd;
                model_mask[wa] = 1'b1;
            end
        end
        #1;
        checkOutput("read_data_a", read_data_a, exp_a);
        checkOutput("read_data_b", read_data_b, exp_b);
        checkOutput("written_mask", {8'h00, written_mask}, {8'h00, model_mask});
    endtask

    initial begin
        reset        = 1'b1;
        enable_write = 1'b0;
        write_addr   = 3'd0;
        write_data   = 16'h0000;
        read_addr_a  = 3'd0;
        read_addr_b  = 3'd0;

        // Reset held two cycles with a write pending; the write must be lost.
        applyStimulus(1'b1, 1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd3);
        applyStimulus(1'b1, 1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd3);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);
        checkOutput("reset_entry3", read_data_a, 16'h0000);

        // Basic write then read.
        applyStimulus(1'b0, 1'b1, 3'd5, 16'h6666, 3'd1, 3'd1);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd0);
        checkOutput("basic_read", read_data_a, 16'h6666);
        checkOutput("basic_mask", {8'h00, written_mask}, 16'h0020);

        // Write disable, then re-enable.
        applyStimulus(1'b0, 1'b0, 3'd5, 16'h0002, 3'd5, 3'd5);
        checkOutput("disabled_write", read_data_a, 16'h6666);
        applyStimulus(1'b0, 1'b1, 3'd5, 16'h0004, 3'd1, 3'd1);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5);
        checkOutput("reenabled_write", read_data_b, 16'h0004);

        // Bypass on both ports from the same write.
        applyStimulus(1'b0, 1'b1, 3'd2, 16'h5555, 3'd0, 3'd0);
        applyStimulus(1'b0, 1'b1, 3'd2, 16'h1234, 3'd2, 3'd2);
        checkOutput("bypass_a", read_data_a, 16'h1234);
        checkOutput("bypass_b", read_data_b, 16'h1234);

        // Entry 0 stays zero, including under bypass.
        applyStimulus(1'b0, 1'b1, 3'd0, 16'hBEEF, 3'd0, 3'd0);
        checkOutput("r0_bypass", read_data_a, 16'h0000);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        checkOutput("r0_mask", {15'h0000, written_mask[0]}, 16'h0000);

        // Fill entries 1..7 and read back pairs.
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 3'(i), 16'(i * 16'h1111), 3'd0, 3'd0);
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd7);
        checkOutput("fill_a_1", read_data_a, 16'h1111);
        checkOutput("fill_b_7", read_data_b, 16'h7777);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd4);
        checkOutput("fill_a_3", read_data_a, 16'h3333);
        checkOutput("fill_b_4", read_data_b, 16'h4444);
        checkOutput("fill_mask", {8'h00, written_mask}, 16'h00FE);

        // Random traffic with occasional mid-stream reset and biased bypass hits.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] wa;
            logic [2:0] ra;
            logic [2:0] rb;
            wa = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
                          wa, 16'($urandom), ra, rb);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
